// File: rtl/disp_trace.sv
// disp_trace: captures one frame of W sample sets, then draws a connected
// trace per enabled channel into the selected framebuffer via the arbiter.
module disp_trace #(
    parameter int              CH   = 2,
    parameter int              DN   = 10,
    parameter int              AN   = 24,
    parameter logic [AN-1:0]   BASE = '0,
    parameter logic [AN-1:0]   SWAP = '0,
    parameter int              W    = 320,
    parameter int              H    = 240
) (
    input  logic                 clkSYS,
    input  logic                 n_reset,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    input  logic                 stat,
    input  logic [CH-1:0]        ch_en,
    input  logic [16*CH-1:0]     colour,
    input  logic                 smpl_valid,
    output logic                 smpl_ready,
    input  logic [DN*CH-1:0]     smpl_data,
    output logic                 arb_req,
    input  logic                 arb_ack,
    output logic [AN-1:0]        arb_addr,
    output logic [15:0]          arb_data,
    output logic                 arb_wr
);

    localparam int XB = $clog2(W);
    localparam int YB = $clog2(H);
    localparam int YW = DN + YB;
    localparam int CB = $clog2(CH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPT, S_CHSEL, S_FETCH,
        S_CALC, S_STEP, S_REQ, S_FIN
    } state_t;

    state_t r_state, w_next;

    logic [DN*CH-1:0] r_mem [W];
    logic [DN*CH-1:0] r_rd;
    logic             r_stat;
    logic [CH-1:0]    r_en;
    logic [16*CH-1:0] r_col;
    logic [XB-1:0]    r_n;
    logic [XB-1:0]    r_x;
    logic [CB-1:0]    r_ch;
    logic [YB-1:0]    r_ydest;
    logic [YB-1:0]    r_yprev;
    logic [YB-1:0]    r_ycur;
    logic             r_first;
    logic             r_req;
    logic [AN-1:0]    r_addr;
    logic [15:0]      r_data;

    logic             w_cen;
    logic             w_more;
    logic [DN-1:0]    w_smp;
    logic [15:0]      w_col;
    logic [YB-1:0]    w_q;
    logic [YB-1:0]    w_yd;
    logic [YB-1:0]    w_ynext;
    logic [AN-1:0]    w_off;
    logic [AN-1:0]    w_addr;
    logic             w_xlast;
    logic             w_nlast;
    logic             w_acc;

    // Per-channel selects; w_more flags an enabled channel above the current one
    always_comb begin
        w_cen  = 1'b0;
        w_more = 1'b0;
        w_smp  = '0;
        w_col  = '0;
        for (int c = 0; c < CH; c++) begin
            if (c == int'(r_ch)) begin
                w_cen = r_en[c];
                w_smp = r_rd[c*DN +: DN];
                w_col = r_col[c*16 +: 16];
            end
            if (c > int'(r_ch) && r_en[c]) begin
                w_more = 1'b1;
            end
        end
    end

    assign w_q     = YB'((YW'(w_smp) * YW'(H)) >> DN);
    assign w_yd    = YB'(H - 1) - w_q;
    assign w_xlast = (r_x == XB'(W - 1));
    assign w_nlast = (r_n == XB'(W - 1));
    assign w_acc   = smpl_valid && (r_state == S_CAPT);

    // Step one pixel toward ydest; the first column of a channel is a single pixel
    always_comb begin
        w_ynext = r_ydest;
        if (!r_first) begin
            if (r_ydest > r_yprev) begin
                w_ynext = r_yprev + YB'(1);
            end else if (r_ydest < r_yprev) begin
                w_ynext = r_yprev - YB'(1);
            end
        end
    end

    assign w_off  = AN'(w_ynext) * AN'(W) + AN'(r_x);
    assign w_addr = (r_stat ? SWAP : BASE) | w_off;

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_CAPT;
            S_CAPT:  if (smpl_valid && w_nlast) w_next = S_CHSEL;
            S_CHSEL: begin
                if (int'(r_ch) >= CH) begin
                    w_next = S_FIN;
                end else if (w_cen) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: w_next = S_CALC;
            S_CALC:  w_next = S_STEP;
            S_STEP:  w_next = S_REQ;
            S_REQ: begin
                if (arb_ack) begin
                    if (r_ycur != r_ydest) begin
                        w_next = S_STEP;
                    end else if (!w_xlast) begin
                        w_next = S_FETCH;
                    end else if (w_more) begin
                        w_next = S_CHSEL;
                    end else begin
                        w_next = S_FIN;
                    end
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clkSYS) begin
        if (w_acc) begin
            r_mem[r_n] <= smpl_data;
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_rd    <= '0;
            r_stat  <= 1'b0;
            r_en    <= '0;
            r_col   <= '0;
            r_n     <= '0;
            r_x     <= '0;
            r_ch    <= '0;
            r_ydest <= '0;
            r_yprev <= '0;
            r_ycur  <= '0;
            r_first <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stat <= stat;
                        r_en   <= ch_en;
                        r_col  <= colour;
                        r_n    <= '0;
                        r_ch   <= '0;
                    end
                end
                S_CAPT: begin
                    if (smpl_valid) r_n <= r_n + XB'(1);
                end
                S_CHSEL: begin
                    if (w_cen) begin
                        r_x     <= '0;
                        r_first <= 1'b1;
                    end else begin
                        r_ch <= r_ch + CB'(1);
                    end
                end
                S_FETCH: r_rd <= r_mem[r_x];
                S_CALC:  r_ydest <= w_yd;
                S_STEP: begin
                    r_ycur <= w_ynext;
                    r_addr <= w_addr;
                    r_data <= w_col;
                    r_req  <= 1'b1;
                end
                S_REQ: begin
                    if (arb_ack) begin
                        r_req   <= 1'b0;
                        r_yprev <= r_ycur;
                        r_first <= 1'b0;
                        if (r_ycur == r_ydest) begin
                            if (!w_xlast) begin
                                r_x <= r_x + XB'(1);
                            end else begin
                                r_ch <= r_ch + CB'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done       = (r_state == S_FIN);
    assign busy       = (r_state != S_IDLE);
    assign smpl_ready = (r_state == S_CAPT);
    assign arb_req    = r_req;
    assign arb_addr   = r_addr;
    assign arb_data   = r_data;
    assign arb_wr     = 1'b1;

endmodule

// File: tb/tb_disp_trace.sv
// tb_disp_trace: table-driven frames plus a reset-mid-draw sequence,
// with a behavioural trace model and arbiter handshake checks.
module tb_disp_trace;

    localparam int CH = 2;
    localparam int DN = 10;
    localparam int AN = 24;
    localparam int W  = 320;
    localparam int H  = 240;
    localparam logic [AN-1:0] BASE = 24'h400000;
    localparam logic [AN-1:0] SWAP = 24'h420000;
    localparam logic [15:0]   C0   = 16'hF800;
    localparam logic [15:0]   C1   = 16'h07E0;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              start = 1'b0;
    logic              stat = 1'b0;
    logic [CH-1:0]     ch_en = '0;
    logic [16*CH-1:0]  colour = '0;
    logic              smpl_valid = 1'b0;
    logic [DN*CH-1:0]  smpl_data = '0;
    logic              arb_ack = 1'b0;
    logic              done, busy, smpl_ready, arb_req, arb_wr;
    logic [AN-1:0]     arb_addr;
    logic [15:0]       arb_data;

    disp_trace #(
        .CH(CH), .DN(DN), .AN(AN), .BASE(BASE),
        .SWAP(SWAP), .W(W), .H(H)
    ) dut (
        .clkSYS(clk), .n_reset(n_reset), .start(start),
        .done(done), .busy(busy), .stat(stat), .ch_en(ch_en),
        .colour(colour), .smpl_valid(smpl_valid),
        .smpl_ready(smpl_ready), .smpl_data(smpl_data),
        .arb_req(arb_req), .arb_ack(arb_ack), .arb_addr(arb_addr),
        .arb_data(arb_data), .arb_wr(arb_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] en;
        logic          st;
        int            mode;
        int            ackmax;
        bit            tog;
        bit            noise;
        int            exp_n;
        int            ci;
        logic [AN-1:0] fa;
        logic [15:0]   fd;
        logic [AN-1:0] ca;
        logic [15:0]   cd;
    } vec_t;

    vec_t tbl[5];
    int   errs = 0;
    int   checks = 0;
    int   smp[W][CH];
    logic [AN-1:0] got_a[$];
    logic [AN-1:0] exp_a[$];
    logic [15:0]   got_d[$];
    logic [15:0]   exp_d[$];
    int   stab_err, req_err, done_cnt, done_g, last_ack_g;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic fill(input int mode);
        int v;
        for (int c = 0; c < CH; c++) begin
            v = 500;
            for (int x = 0; x < W; x++) begin
                if (mode == 0) begin
                    smp[x][c] = (c == 0) ? 512 : 0;
                end else if (mode == 1) begin
                    smp[x][c] = (x == 0) ? 0 : 1023;
                end else begin
                    v = v + int'($urandom_range(0, 32)) - 16;
                    if (v < 0) v = 0;
                    if (v > 1023) v = 1023;
                    smp[x][c] = v;
                end
            end
        end
    endtask

    task automatic push_exp(input vec_t v, input int y, input int x, input int c);
        exp_a.push_back((v.st ? SWAP : BASE) | AN'(y * W + x));
        exp_d.push_back(c == 0 ? C0 : C1);
    endtask

    task automatic model(input vec_t v);
        int yp, yd;
        exp_a.delete();
        exp_d.delete();
        for (int c = 0; c < CH; c++) begin
            if (v.en[c]) begin
                yp = 0;
                for (int x = 0; x < W; x++) begin
                    yd = (H - 1) - ((smp[x][c] * H) >> DN);
                    if (x == 0 || yd == yp) begin
                        push_exp(v, yd, x, c);
                    end else begin
                        while (yp != yd) begin
                            yp = yp + ((yd > yp) ? 1 : -1);
                            push_exp(v, yp, x, c);
                        end
                    end
                    yp = yd;
                end
            end
        end
    endtask

    task automatic capture(input vec_t v);
        int  i, g;
        bit  acc;
        @(negedge clk);
        start  = 1'b1;
        stat   = v.st;
        ch_en  = v.en;
        colour = {C1, C0};
        @(negedge clk);
        start = 1'b0;
        chk("ready_rise", longint'(smpl_ready), 1);
        i = 0;
        g = 0;
        while (i < W && g < 4000) begin
            smpl_valid = v.tog ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int c = 0; c < CH; c++) begin
                smpl_data[c*DN +: DN] = DN'(smp[i][c]);
            end
            acc = smpl_valid && smpl_ready;
            @(negedge clk);
            g++;
            if (acc) i++;
        end
        chk("accepted", i, W);
        chk("ready_drop", longint'(smpl_ready), 0);
        smpl_valid = 1'b1;
        smpl_data  = '1;
    endtask

    task automatic serve(input int ackmax, input bit noise, input int stop_at);
        int  g, wn;
        bit  pend, ackp;
        logic [AN-1:0] ha;
        logic [15:0]   hd;
        g = 0;
        wn = 0;
        pend = 1'b0;
        ackp = 1'b0;
        ha = '0;
        hd = '0;
        while (g < 60000) begin
            @(negedge clk);
            g++;
            if (stop_at > 0 && got_a.size() >= stop_at && arb_req) begin
                arb_ack = 1'b0;
                return;
            end
            if (ackp && arb_req) req_err++;
            if (done) begin
                done_cnt++;
                done_g = g;
            end
            if (done_cnt > 0 && g >= done_g + 3) break;
            ackp = 1'b0;
            arb_ack = 1'b0;
            if (arb_req) begin
                if (!pend) begin
                    pend = 1'b1;
                    ha = arb_addr;
                    hd = arb_data;
                    wn = int'($urandom_range(0, ackmax));
                end else if (arb_addr != ha || arb_data != hd) begin
                    stab_err++;
                end
                if (wn == 0) begin
                    arb_ack = 1'b1;
                    ackp = 1'b1;
                    got_a.push_back(ha);
                    got_d.push_back(hd);
                    last_ack_g = g;
                    pend = 1'b0;
                end else begin
                    wn--;
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                arb_ack = 1'b1;
            end
        end
        arb_ack = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input int stop_at);
        int bad, n;
        got_a.delete();
        got_d.delete();
        stab_err = 0;
        req_err = 0;
        done_cnt = 0;
        done_g = 0;
        last_ack_g = -10;
        fill(v.mode);
        model(v);
        capture(v);
        serve(v.ackmax, v.noise, stop_at);
        smpl_valid = 1'b0;
        if (stop_at > 0) begin
            chk("reach_mid", longint'(got_a.size() >= stop_at), 1);
            return;
        end
        chk("done_once", done_cnt, 1);
        chk("busy_end", longint'(busy), 0);
        chk("addr_stable", stab_err, 0);
        chk("req_after_ack", req_err, 0);
        chk("count_model", got_a.size(), exp_a.size());
        if (v.exp_n >= 0) chk("count_hand", got_a.size(), v.exp_n);
        if (got_a.size() > 0) chk("done_lat", done_g, last_ack_g + 1);
        bad = 0;
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) bad++;
        end
        chk("pixels", bad, 0);
        if (v.ci >= 0 && got_a.size() > v.ci) begin
            chk("first_addr", got_a[0], v.fa);
            chk("first_data", got_d[0], v.fd);
            chk("pt_addr", got_a[v.ci], v.ca);
            chk("pt_data", got_d[v.ci], v.cd);
        end
    endtask

    initial begin
        tbl[0] = '{2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 320, 319,
                   BASE + 24'(119*W), C0, BASE + 24'(119*W + 319), C0};
        tbl[1] = '{2'b01, 1'b1, 1, 2, 1'b0, 1'b0, 558, 239,
                   SWAP + 24'(239*W), C0, SWAP + 24'(1), C0};
        tbl[2] = '{2'b11, 1'b0, 0, 1, 1'b0, 1'b0, 640, 320,
                   BASE + 24'(119*W), C0, BASE + 24'(239*W), C1};
        tbl[3] = '{2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 0, -1,
                   '0, '0, '0, '0};
        tbl[4] = '{2'b11, 1'b1, 2, 20, 1'b1, 1'b1, -1, -1,
                   '0, '0, '0, '0};

        repeat (3) @(negedge clk);
        chk("rst_done", longint'(done), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ready", longint'(smpl_ready), 0);
        chk("rst_req", longint'(arb_req), 0);
        chk("rst_addr", arb_addr, 0);
        chk("rst_data", arb_data, 0);
        chk("rst_wr", longint'(arb_wr), 1);
        n_reset = 1'b1;

        for (int r = 0; r < 5; r++) begin
            run_row(tbl[r], 0);
        end

        run_row(tbl[0], 50);
        n_reset = 1'b0;
        #1;
        chk("mid_busy", longint'(busy), 0);
        chk("mid_done", longint'(done), 0);
        chk("mid_req", longint'(arb_req), 0);
        chk("mid_ready", longint'(smpl_ready), 0);
        chk("mid_addr", arb_addr, 0);
        chk("mid_data", arb_data, 0);
        chk("mid_wr", longint'(arb_wr), 1);
        @(negedge clk);
        n_reset = 1'b1;
        run_row(tbl[2], 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
